// File: rtl/md_sched_if.sv
// Bundle between the E/D pipeline stages and the HI/LO multiply/divide sequencer.
interface md_sched_if;
    logic        e_valid;
    logic [3:0]  e_md_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        d_md_use;
    logic [3:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_start;
    logic        md_busy;
    logic        d_stall;
    logic        hilo_commit;
    logic        hi_we;
    logic        lo_we;
    logic        proto_err;

    // Pipeline side: issues ops, consumes stall/commit strobes.
    modport master (
        output e_valid, e_md_op, e_a, e_b, d_md_use,
        input  md_op, md_a, md_b, md_start, md_busy, d_stall, hilo_commit, hi_we, lo_we,
               proto_err
    );

    // Sequencer side.
    modport slave (
        input  e_valid, e_md_op, e_a, e_b, d_md_use,
        output md_op, md_a, md_b, md_start, md_busy, d_stall, hilo_commit, hi_we, lo_we,
               proto_err
    );
endinterface

// File: rtl/md_sched.sv
// Issue/hazard sequencer for the HI/LO multiply/divide unit: latches the op and
// operands, counts the fixed latency, stalls D for HI/LO-class instructions and
// pulses the HI/LO commit on the last busy cycle.
module md_sched #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = $clog2(DIV_LAT + 1)
) (
    input  logic      clk,
    input  logic      reset,
    md_sched_if.slave bus
);

    localparam logic [3:0] OpNone  = 4'd0;
    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;

    localparam logic [CNT_W-1:0] MultCnt = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DivCnt  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              err_q, err_d;
    logic              start, commit, hi_wr, lo_wr;
    logic              is_mul, is_div, is_mt;

    assign is_mul = (bus.e_md_op == OpMult) || (bus.e_md_op == OpMultu);
    assign is_div = (bus.e_md_op == OpDiv) || (bus.e_md_op == OpDivu);
    assign is_mt  = (bus.e_md_op == OpMthi) || (bus.e_md_op == OpMtlo);

    // Next-state: issue in IDLE, count down in RUN, flag ops that arrive while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        start   = 1'b0;
        commit  = 1'b0;
        hi_wr   = 1'b0;
        lo_wr   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.e_valid && (is_mul || is_div)) begin
                    start   = 1'b1;
                    op_d    = bus.e_md_op;
                    a_d     = bus.e_a;
                    b_d     = bus.e_b;
                    cnt_d   = is_div ? DivCnt : MultCnt;
                    state_d = StRun;
                end else if (bus.e_valid && (bus.e_md_op == OpMthi)) begin
                    hi_wr = 1'b1;
                end else if (bus.e_valid && (bus.e_md_op == OpMtlo)) begin
                    lo_wr = 1'b1;
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    commit  = 1'b1;
                    op_d    = OpNone;
                    state_d = StIdle;
                end
                // Op is dropped; only the sticky flag records it.
                if (bus.e_valid && (is_mul || is_div || is_mt)) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latched operands; reset abandons any run without a commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OpNone;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    // Combinational strobes are forced low while reset is asserted.
    assign bus.md_start    = start & ~reset;
    assign bus.hilo_commit = commit & ~reset;
    assign bus.hi_we       = hi_wr & ~reset;
    assign bus.lo_we       = lo_wr & ~reset;
    assign bus.md_busy     = (state_q == StRun);
    assign bus.d_stall     = bus.d_md_use & (bus.md_busy | bus.md_start);
    assign bus.md_op       = op_q;
    assign bus.md_a        = a_q;
    assign bus.md_b        = b_q;
    assign bus.proto_err   = err_q;

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: table of single-cycle IDLE decode vectors, hand-written
// multi-cycle sequences, and a commit scoreboard checked by a monitor.
module tb_md_sched;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    md_sched_if sif();

    md_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        duse;
        logic        e_start;
        logic        e_hi;
        logic        e_lo;
        logic        e_stall;
    } vec_t;

    typedef struct {
        int          exp_cyc;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } sb_t;

    vec_t vecs[14];
    sb_t  sb[$];
    sb_t  mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic duse);
        sif.e_valid  = v;
        sif.e_md_op  = op;
        sif.e_a      = a;
        sif.e_b      = b;
        sif.d_md_use = duse;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = (op == 4'd3 || op == 4'd4) ? 10 : 5;
        sb.push_back('{cyc + lat, op, a, b});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!sif.md_busy) break;
            next_cycle();
        end
        chk("idle_reached", {31'd0, sif.md_busy}, 32'd0);
    endtask

    // Commit monitor: every commit must match the oldest expected issue.
    always @(negedge clk) begin
        if (!reset && sif.hilo_commit) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("commit_cycle", cyc, mon_e.exp_cyc);
                chk("commit_op", {28'd0, sif.md_op}, {28'd0, mon_e.op});
                chk("commit_a", sif.md_a, mon_e.a);
                chk("commit_b", sif.md_b, mon_e.b);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          valid op     a             b      duse start hi    lo    stall
        vecs[0]  = '{1'b0, 4'd1, 32'd7,       32'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'd0, 32'd1,       32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'd7, 32'd1,       32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'd8, 32'd1,       32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'd9, 32'd1,       32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'd15, 32'd1,      32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'd5, 32'h1234,    32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'd6, 32'h5678,    32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'd5, 32'h1234,    32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'd1, 32'd11,      32'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 4'd2, 32'hFFFF0000, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 4'd3, 32'd100,     32'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 4'd4, 32'hDEAD,    32'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 4'd3, 32'd1,       32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state, with an issuing op on the inputs to prove strobes are gated.
        drive(1'b1, 4'd1, 32'd1, 32'd1, 1'b1);
        #1 reset = 1'b1;
        #2;
        chk("rst_busy", {31'd0, sif.md_busy}, 32'd0);
        chk("rst_op", {28'd0, sif.md_op}, 32'd0);
        chk("rst_a", sif.md_a, 32'd0);
        chk("rst_b", sif.md_b, 32'd0);
        chk("rst_err", {31'd0, sif.proto_err}, 32'd0);
        chk("rst_start", {31'd0, sif.md_start}, 32'd0);
        chk("rst_stall", {31'd0, sif.d_stall}, 32'd0);
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        reset = 1'b0;
        next_cycle();

        // Single-cycle decode in IDLE.
        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].duse);
            @(negedge clk);
            chk($sformatf("v%0d_start", i), {31'd0, sif.md_start}, {31'd0, vecs[i].e_start});
            chk($sformatf("v%0d_hi_we", i), {31'd0, sif.hi_we}, {31'd0, vecs[i].e_hi});
            chk($sformatf("v%0d_lo_we", i), {31'd0, sif.lo_we}, {31'd0, vecs[i].e_lo});
            chk($sformatf("v%0d_stall", i), {31'd0, sif.d_stall}, {31'd0, vecs[i].e_stall});
            chk($sformatf("v%0d_busy", i), {31'd0, sif.md_busy}, 32'd0);
            chk($sformatf("v%0d_commit", i), {31'd0, sif.hilo_commit}, 32'd0);
            if (vecs[i].e_start) push_exp(vecs[i].op, vecs[i].a, vecs[i].b);
            next_cycle();
            drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            if (!vecs[i].e_start) chk($sformatf("v%0d_busy_after", i), {31'd0, sif.md_busy}, 32'd0);
            wait_idle();
        end

        // MULT 3 * -2: operands held while E-stage contents wander.
        drive(1'b1, 4'd1, 32'd3, 32'hFFFFFFFE, 1'b0);
        @(negedge clk);
        chk("mult_start", {31'd0, sif.md_start}, 32'd1);
        push_exp(4'd1, 32'd3, 32'hFFFFFFFE);
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            drive(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom, 1'b0);
            @(negedge clk);
            chk($sformatf("mult_busy_c%0d", k), {31'd0, sif.md_busy}, {31'd0, k <= 5});
            chk($sformatf("mult_commit_c%0d", k), {31'd0, sif.hilo_commit}, {31'd0, k == 5});
            chk($sformatf("mult_op_c%0d", k), {28'd0, sif.md_op}, (k <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("mult_a_c%0d", k), sif.md_a, 32'd3);
            chk($sformatf("mult_b_c%0d", k), sif.md_b, 32'hFFFFFFFE);
        end
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

        // DIVU with an MFLO waiting in D.
        drive(1'b1, 4'd4, 32'd100, 32'd7, 1'b1);
        @(negedge clk);
        chk("divu_start", {31'd0, sif.md_start}, 32'd1);
        chk("divu_stall_c0", {31'd0, sif.d_stall}, 32'd1);
        push_exp(4'd4, 32'd100, 32'd7);
        for (int k = 1; k <= 11; k++) begin
            next_cycle();
            drive(1'b0, 4'd8, 32'd0, 32'd0, 1'b1);
            @(negedge clk);
            chk($sformatf("divu_stall_c%0d", k), {31'd0, sif.d_stall}, {31'd0, k <= 10});
            chk($sformatf("divu_commit_c%0d", k), {31'd0, sif.hilo_commit}, {31'd0, k == 10});
        end
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

        // Protocol violation: MULTU and MTHI during a MULT run are ignored.
        drive(1'b1, 4'd1, 32'd5, 32'd6, 1'b0);
        @(negedge clk);
        chk("pv_start", {31'd0, sif.md_start}, 32'd1);
        push_exp(4'd1, 32'd5, 32'd6);
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k == 2) drive(1'b1, 4'd2, 32'd9, 32'd9, 1'b0);
            else if (k == 3) drive(1'b1, 4'd5, 32'd9, 32'd9, 1'b0);
            else drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            @(negedge clk);
            chk($sformatf("pv_err_c%0d", k), {31'd0, sif.proto_err}, {31'd0, k >= 3});
            chk($sformatf("pv_start_c%0d", k), {31'd0, sif.md_start}, 32'd0);
            chk($sformatf("pv_hi_we_c%0d", k), {31'd0, sif.hi_we}, 32'd0);
            chk($sformatf("pv_op_c%0d", k), {28'd0, sif.md_op}, (k <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("pv_a_c%0d", k), sif.md_a, 32'd5);
        end
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

        // Reset in the middle of a DIV run: state clears at once, no commit later.
        drive(1'b1, 4'd3, 32'd50, 32'd5, 1'b0);
        @(negedge clk);
        chk("rr_start", {31'd0, sif.md_start}, 32'd1);
        push_exp(4'd3, 32'd50, 32'd5);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        end
        #1 reset = 1'b1;
        #1;
        chk("rr_busy", {31'd0, sif.md_busy}, 32'd0);
        chk("rr_op", {28'd0, sif.md_op}, 32'd0);
        chk("rr_err", {31'd0, sif.proto_err}, 32'd0);
        chk("rr_a", sif.md_a, 32'd0);
        sb.delete();
        #1 reset = 1'b0;
        for (int k = 5; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("rr_commit_c%0d", k), {31'd0, sif.hilo_commit}, 32'd0);
            chk($sformatf("rr_busy_c%0d", k), {31'd0, sif.md_busy}, 32'd0);
            next_cycle();
        end

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
